// File: rtl/cvae_pkg.sv
// Shared types and helpers for the CVAE SRAM arbiters.
// Holds FSM encoding, burst-length defaults, length clamp and id width.
package cvae_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int LEN_W_DEF     = 6;
    localparam int MAX_BURST_DEF = 32;

    // Zero-length bursts still read one word; long ones are cut down.
    function automatic int clamp_len(input int len, input int max_burst);
        if (len == 0)
            return 1;
        if (len > max_burst)
            return max_burst;
        return len;
    endfunction

    // At least one bit so a single-requester build still elaborates.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/cvae_wsram_rd_arbiter_if.sv
// Requester-side bundle of the weight/bias SRAM read arbiter.
// master: compute engines (req, req_addr, req_len in; gnt, rdata* out).
// slave : the arbiter (drives gnt, rdata, rdata_valid, rdata_last).
interface cvae_wsram_rd_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 6
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]      req_len;
    logic [NUM_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [NUM_REQ-1:0]            rdata_valid;
    logic [NUM_REQ-1:0]            rdata_last;

    modport master (
        output req, req_addr, req_len,
        input  gnt, rdata, rdata_valid, rdata_last
    );

    modport slave (
        input  req, req_addr, req_len,
        output gnt, rdata, rdata_valid, rdata_last
    );
endinterface

// File: rtl/cvae_rr_pick.sv
// Combinational round-robin selector: first req at or after ptr+1 (mod N).
// Ports: req, ptr in; one-hot pick and any_req out.
module cvae_rr_pick
    import cvae_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any_req
);
    int   idx;
    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/cvae_wsram_rd_arbiter.sv
// Round-robin burst read arbiter for a single-port synchronous-read SRAM.
// Ports: clk, rst; rq (requester bundle); busy, sram_addr, sram_rdata.
module cvae_wsram_rd_arbiter
    import cvae_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    cvae_wsram_rd_arbiter_if.slave  rq,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);
    localparam int IDW = id_width(NUM_REQ);

    typedef struct packed {
        logic           valid;
        logic           last;
        logic [IDW-1:0] id;
    } rsp_t;

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [IDW-1:0]        ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [LEN_W-1:0]      len_q;

    logic [NUM_REQ-1:0]    pick;
    logic                  any_req;
    logic [IDW-1:0]        sel_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_W-1:0]      sel_len;
    logic                  last_beat;
    logic                  grant;

    rsp_t                  pipe_q [RD_LATENCY];
    rsp_t                  rsp_in;
    rsp_t                  rsp_out;

    cvae_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req     (rq.req),
        .ptr     (ptr_q),
        .pick    (pick),
        .any_req (any_req)
    );

    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                sel_id   = IDW'(i);
                sel_addr = rq.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = rq.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign busy      = (state_q == BURST);
    assign last_beat = busy && (cnt_q == len_q - LEN_W'(1));
    // A grant seen during reset would be lost, so it is never shown.
    assign grant     = (state_q == IDLE) && any_req && !rst;
    assign sram_addr = addr_q;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rq.gnt  = '0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    rq.gnt  = pick;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (last_beat)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // addr_q walks the burst directly; it holds after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= IDW'(NUM_REQ - 1);
            addr_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
        end else if (grant) begin
            ptr_q  <= sel_id;
            addr_q <= sel_addr;
            cnt_q  <= '0;
            len_q  <= LEN_W'(clamp_len(int'(sel_len), MAX_BURST));
        end else if (busy && !last_beat) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            cnt_q  <= cnt_q + LEN_W'(1);
        end
    end

    // Response tags trail the issued address by the SRAM read latency.
    always_comb begin
        rsp_in       = '0;
        rsp_in.valid = busy;
        rsp_in.last  = last_beat;
        rsp_in.id    = ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++)
                pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= rsp_in;
            for (int i = 1; i < RD_LATENCY; i++)
                pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rsp_out  = pipe_q[RD_LATENCY-1];
    assign rq.rdata = sram_rdata;

    always_comb begin
        rq.rdata_valid = '0;
        rq.rdata_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_out.valid && rsp_out.id == IDW'(i)) begin
                rq.rdata_valid[i] = 1'b1;
                rq.rdata_last[i]  = rsp_out.last;
            end
        end
    end
endmodule

// File: tb/tb_cvae_wsram_rd_arbiter.sv
// Directed bench for cvae_wsram_rd_arbiter with a 1-cycle SRAM model.
// Burst table plus sequences for contention, reset and request withdrawal.
module tb_cvae_wsram_rd_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] sram_addr;
    logic [31:0] sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    cvae_wsram_rd_arbiter_if #(
        .NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .LEN_W(6)
    ) bus ();

    cvae_wsram_rd_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(32),
        .LEN_W(6), .MAX_BURST(32), .RD_LATENCY(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rq         (bus),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    always @(posedge clk) sram_rdata <= mem_word(sram_addr);

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          r;
        logic [15:0] base;
        logic [5:0]  len;
        int          n;
        logic [15:0] end_addr;
    } vec_t;

    vec_t vt [8];

    task automatic run_burst(input vec_t v);
        logic [1:0] oh;
        bit         got;
        oh = 2'b01 << v.r;
        bus.req_addr[v.r*16 +: 16] = v.base;
        bus.req_len[v.r*6 +: 6]    = v.len;
        bus.req[v.r]               = 1'b1;
        #1;
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (bus.gnt != 2'b00) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("burst_gnt", {30'd0, bus.gnt}, {30'd0, oh});
        if (!got) begin
            bus.req = '0;
            return;
        end
        tick();
        bus.req[v.r]  = 1'b0;
        bus.req_addr  = '1;
        bus.req_len   = '1;
        for (int c = 1; c <= v.n + 1; c++) begin
            if (c > 1)
                tick();
            if (c <= v.n) begin
                check("burst_busy", {31'd0, busy}, 32'd1);
                check("burst_addr", {16'd0, sram_addr},
                      {16'd0, v.base + 16'(c - 1)});
                if (c == v.n)
                    check("burst_end_addr", {16'd0, sram_addr},
                          {16'd0, v.end_addr});
            end
            if (c == 1) begin
                check("burst_no_valid", {30'd0, bus.rdata_valid}, 32'd0);
            end else begin
                check("burst_valid", {30'd0, bus.rdata_valid}, {30'd0, oh});
                check("burst_rdata", bus.rdata,
                      mem_word(v.base + 16'(c - 2)));
                check("burst_last", {30'd0, bus.rdata_last},
                      (c == v.n + 1) ? {30'd0, oh} : 32'd0);
            end
        end
        tick();
        check("burst_idle_busy", {31'd0, busy}, 32'd0);
        check("burst_idle_valid", {30'd0, bus.rdata_valid}, 32'd0);
    endtask

    int exp_g  [12];
    int exp_b  [12];
    int exp_v  [12];
    int exp_a  [12];

    initial begin
        vt[0] = '{0, 16'h0100, 6'd4,  4,  16'h0103};
        vt[1] = '{1, 16'h0A00, 6'd3,  3,  16'h0A02};
        vt[2] = '{0, 16'hFFFE, 6'd4,  4,  16'h0001};
        vt[3] = '{1, 16'h0010, 6'd0,  1,  16'h0010};
        vt[4] = '{0, 16'h1000, 6'd40, 32, 16'h101F};
        vt[5] = '{1, 16'h2000, 6'd32, 32, 16'h201F};
        vt[6] = '{0, 16'h3000, 6'd33, 32, 16'h301F};
        vt[7] = '{1, 16'h7FFF, 6'd1,  1,  16'h7FFF};

        exp_g = '{1, 0, 0, 2, 0, 0, 1, 0, 0, 2, 0, 0};
        exp_b = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        exp_v = '{0, 0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2};
        exp_a = '{0, 'h200, 'h201, 0, 'h300, 'h301,
                  0, 'h200, 'h201, 0, 'h300, 'h301};

        rst          = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_len  = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_gnt", {30'd0, bus.gnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {16'd0, sram_addr}, 32'd0);
        check("rst_valid", {30'd0, bus.rdata_valid}, 32'd0);
        check("rst_last", {30'd0, bus.rdata_last}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            tick();
            run_burst(vt[i]);
        end

        // Contention: both hold req, len 2; pointer reset favours 0.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_addr = {16'h0300, 16'h0200};
        bus.req_len  = {6'd2, 6'd2};
        bus.req      = 2'b11;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0)
                tick();
            check("rr_gnt", {30'd0, bus.gnt}, 32'(exp_g[i]));
            check("rr_busy", {31'd0, busy}, 32'(exp_b[i]));
            check("rr_valid", {30'd0, bus.rdata_valid}, 32'(exp_v[i]));
            if (exp_b[i] == 1)
                check("rr_addr", {16'd0, sram_addr}, 32'(exp_a[i]));
        end
        bus.req = 2'b00;
        repeat (4) tick();

        // Reset on the 3rd address cycle of a len-8 burst.
        bus.req_addr[15:0] = 16'h0400;
        bus.req_len[5:0]   = 6'd8;
        bus.req            = 2'b01;
        #1;
        check("rst5_gnt", {30'd0, bus.gnt}, 32'd1);
        tick();
        bus.req = 2'b00;
        check("rst5_addr0", {16'd0, sram_addr}, 32'h0400);
        tick();
        check("rst5_addr1", {16'd0, sram_addr}, 32'h0401);
        tick();
        check("rst5_addr2", {16'd0, sram_addr}, 32'h0402);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst5_busy", {31'd0, busy}, 32'd0);
        check("rst5_addr", {16'd0, sram_addr}, 32'd0);
        check("rst5_valid", {30'd0, bus.rdata_valid}, 32'd0);
        check("rst5_last", {30'd0, bus.rdata_last}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst5_quiet", {30'd0, bus.rdata_valid}, 32'd0);
        end
        bus.req_len = {6'd1, 6'd1};
        bus.req     = 2'b11;
        #1;
        check("rst5_fresh_gnt", {30'd0, bus.gnt}, 32'd1);
        tick();
        bus.req = 2'b00;
        repeat (3) tick();

        // Requester 1 withdraws while requester 0 is mid-burst.
        bus.req_addr[15:0] = 16'h0500;
        bus.req_len[5:0]   = 6'd6;
        bus.req            = 2'b01;
        #1;
        check("wd_gnt0", {30'd0, bus.gnt}, 32'd1);
        tick();
        bus.req = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1)
                tick();
            if (i == 2)
                bus.req[1] = 1'b1;
            if (i == 4)
                bus.req[1] = 1'b0;
            #1;
            check("wd_no_gnt", {30'd0, bus.gnt}, 32'd0);
        end
        bus.req_len = {6'd1, 6'd1};
        bus.req     = 2'b11;
        #1;
        check("wd_next_gnt", {30'd0, bus.gnt}, 32'd2);
        tick();
        bus.req = 2'b00;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
